// File: rtl/stv_packet_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter and its round-robin picker.
package stv_pkt_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } pkt_arb_state_e;

    // Width of a source index; a single requester still gets one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stv_packet_arbiter_pick.sv
// Masked round-robin pick: first valid requester at/above the mask boundary,
// else the lowest-index valid requester. Pure combinational.
module stv_pkt_arb_pick
    import stv_pkt_arb_pkg::*;
#(
    parameter int INPUTS = 4,
    localparam int SRC_W = src_width(INPUTS)
) (
    input  logic [INPUTS-1:0] in_valid,
    input  logic [INPUTS-1:0] prio_mask,
    output logic              any_valid,
    output logic [INPUTS-1:0] grant_oh,
    output logic [SRC_W-1:0]  grant_idx
);

    logic [INPUTS-1:0] masked;
    logic              found;

    assign any_valid = |in_valid;

    always_comb begin
        masked    = in_valid & prio_mask;
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (!found && masked[i]) begin
                grant_oh[i] = 1'b1;
                grant_idx   = SRC_W'(i);
                found       = 1'b1;
            end
        end
        // Nothing above the boundary: wrap to the lowest-index requester.
        for (int i = 0; i < INPUTS; i++) begin
            if (!found && in_valid[i]) begin
                grant_oh[i] = 1'b1;
                grant_idx   = SRC_W'(i);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stv_packet_arbiter.sv
// Packet-granular round-robin arbiter over valid/ready streams with a
// registered output slice. One arbitration bubble per packet.
module stv_packet_arbiter
    import stv_pkt_arb_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int DATA_W = 32,
    localparam int SRC_W = src_width(INPUTS)
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic [INPUTS-1:0]        in_valid,
    output logic [INPUTS-1:0]        in_ready,
    input  logic [INPUTS*DATA_W-1:0] in_data,
    input  logic [INPUTS-1:0]        in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SRC_W-1:0]         out_src,
    output logic                     busy
);

    pkt_arb_state_e    state_q, state_d;
    logic [SRC_W-1:0]  cur_q, cur_d;
    logic [INPUTS-1:0] cur_oh_q, cur_oh_d;
    logic [INPUTS-1:0] prio_mask_q, prio_mask_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;

    logic              any_valid;
    logic [INPUTS-1:0] grant_oh;
    logic [SRC_W-1:0]  grant_idx;

    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              slot_free;
    logic              in_xfer;

    stv_pkt_arb_pick #(
        .INPUTS (INPUTS)
    ) u_pick (
        .in_valid  (in_valid),
        .prio_mask (prio_mask_q),
        .any_valid (any_valid),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx)
    );

    // AND-OR mux on the one-hot owner so unselected inputs (even X) drop out.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < INPUTS; i++) begin
            sel_data = sel_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{cur_oh_q[i]}});
        end
        sel_valid = |(in_valid & cur_oh_q);
        sel_last  = |(in_last & cur_oh_q);
    end

    assign slot_free = !out_valid_q || out_ready;
    assign in_xfer   = (state_q == LOCKED) && sel_valid && slot_free;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cur_oh_d    = cur_oh_q;
        prio_mask_d = prio_mask_q;
        in_ready    = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d  = LOCKED;
                    cur_d    = grant_idx;
                    cur_oh_d = grant_oh;
                end
            end
            LOCKED: begin
                in_ready = cur_oh_q & {INPUTS{slot_free}};
                if (in_xfer && sel_last) begin
                    state_d = IDLE;
                    // Everything above the finished owner gets first claim next.
                    for (int i = 0; i < INPUTS; i++) begin
                        prio_mask_d[i] = (SRC_W'(i) > cur_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_src_d   = cur_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            cur_oh_q    <= '0;
            prio_mask_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cur_oh_q    <= cur_oh_d;
            prio_mask_q <= prio_mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_stv_packet_arbiter.sv
// Randomized bench for stv_packet_arbiter against a transaction-level
// round-robin model with an output scoreboard.
module tb_stv_packet_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;

    logic           clk;
    logic           arst;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SW-1:0]  out_src;
    logic           busy;

    stv_packet_arbiter #(.INPUTS(N), .DATA_W(W)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int         src;
        logic [W-1:0] data;
        bit         last;
    } beat_t;

    // Reference model: who owns the output stream, which input is next in
    // rotation, and the beat currently sitting in the output register.
    bit    m_locked;
    bit    m_ov;
    int    m_owner;
    int    m_next;
    beat_t sb[$];
    int    src_log[$];
    int    n_out;

    // Stimulus generator state and knobs.
    int       rem[N];
    int       seq[N];
    logic [N-1:0] g_en;
    int       g_pstart, g_pvalid, g_pready, g_minlen, g_maxlen;

    function automatic logic [W-1:0] beat_word(input int src, input int s);
        logic [31:0] sv;
        logic [31:0] ss;
        sv = src;
        ss = s;
        return {sv[7:0], ss[23:0]};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bit v;
            if (rem[i] == 0 && g_en[i] && $urandom_range(99) < g_pstart)
                rem[i] = $urandom_range(g_maxlen, g_minlen);
            v = (rem[i] != 0) && ($urandom_range(99) < g_pvalid);
            in_valid[i] = v;
            in_data[i*W +: W] = v ? beat_word(i, seq[i]) : W'($urandom);
            in_last[i] = v ? (rem[i] == 1) : 1'($urandom_range(1));
        end
        out_ready = ($urandom_range(99) < g_pready);
    endtask

    task automatic check_cycle();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (m_locked && (!m_ov || out_ready)) exp_rdy[m_owner] = 1'b1;
        chk("busy", busy, m_locked);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, m_ov);
        if (m_ov && sb.size() > 0) begin
            chk("out_data", out_data, sb[0].data);
            chk("out_last", out_last, sb[0].last);
            chk("out_src", out_src, sb[0].src);
            if (out_ready) begin
                src_log.push_back(int'(out_src));
                n_out++;
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic model_step();
        if (!m_locked) begin
            if (in_valid != '0) begin
                bit found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int j = (m_next + k) % N;
                    if (!found && in_valid[j]) begin
                        m_owner = j;
                        found   = 1'b1;
                    end
                end
                m_locked = 1'b1;
            end
            if (out_ready) m_ov = 1'b0;
        end else if (in_valid[m_owner] && (!m_ov || out_ready)) begin
            beat_t b;
            b.src  = m_owner;
            b.data = beat_word(m_owner, seq[m_owner]);
            b.last = (rem[m_owner] == 1);
            sb.push_back(b);
            m_ov = 1'b1;
            seq[m_owner]++;
            rem[m_owner]--;
            if (b.last) begin
                m_locked = 1'b0;
                m_next   = (m_owner + 1) % N;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            drive();
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
            model_step();
        end
    endtask

    task automatic apply_reset();
        arst      = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_in_ready", in_ready, 0);
        m_locked = 1'b0;
        m_ov     = 1'b0;
        m_owner  = 0;
        m_next   = 0;
        sb.delete();
        for (int i = 0; i < N; i++) rem[i] = 0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic config_gen(input logic [N-1:0] en, input int pstart, input int pvalid,
                              input int pready, input int minlen, input int maxlen);
        g_en     = en;
        g_pstart = pstart;
        g_pvalid = pvalid;
        g_pready = pready;
        g_minlen = minlen;
        g_maxlen = maxlen;
    endtask

    initial begin
        n_out = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        config_gen('0, 0, 0, 100, 1, 1);
        apply_reset();

        // Single 3-beat packet from input 0 at full rate.
        config_gen(4'b0001, 100, 100, 100, 3, 3);
        n_out = 0;
        run(5);
        chk("t1_beats", n_out, 3);

        // Continuous single-beat packets from all inputs: strict rotation.
        apply_reset();
        config_gen(4'b1111, 100, 100, 100, 1, 1);
        src_log.delete();
        run(20);
        if (src_log.size() >= 5) begin
            chk("t2_order0", src_log[0], 0);
            chk("t2_order1", src_log[1], 1);
            chk("t2_order2", src_log[2], 2);
            chk("t2_order3", src_log[3], 3);
            chk("t2_order4", src_log[4], 0);
        end else begin
            chk("t2_count", src_log.size(), 5);
        end

        // Input 2 mid-packet while 1 and 3 request: 3 wins next, then 1.
        apply_reset();
        config_gen(4'b0100, 100, 100, 100, 3, 3);
        src_log.delete();
        run(2);
        config_gen(4'b1110, 100, 100, 100, 1, 1);
        run(10);
        if (src_log.size() >= 5) begin
            chk("t3_after2", src_log[3], 3);
            chk("t3_wrap1", src_log[4], 1);
        end else begin
            chk("t3_count", src_log.size(), 5);
        end

        // Randomized traffic: mixed, heavy back-pressure, sparse valids.
        config_gen(4'b1111, 60, 70, 60, 1, 5);
        run(3000);
        config_gen(4'b1111, 80, 90, 20, 1, 6);
        run(800);
        config_gen(4'b1111, 80, 30, 90, 2, 6);
        run(800);

        // Reset while beat 2 of a 4-beat packet sits in the output register.
        apply_reset();
        config_gen(4'b0100, 100, 100, 100, 4, 4);
        run(3);
        chk("t6_pre_out_valid", out_valid, 1);
        apply_reset();

        // After reset input 0 is top priority again.
        config_gen(4'b1001, 100, 100, 100, 2, 2);
        src_log.delete();
        run(8);
        if (src_log.size() >= 1) chk("t6_first_src", src_log[0], 0);
        else chk("t6_count", src_log.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
